qpd_shot_sequencer: RTL
=======================

Name: qpd_shot_sequencer

Overview:
Sequences quarter-period-delayed trigger shots for a measurement run. On a start request it latches the run configuration and repeats a per-shot cycle of num_shots shots. Each shot is: programmable delay, one-cycle trigger, acquisition window of acq_samples cycles, fixed holdoff. It sits between the control/C-server register interface and the sampling front end, and exposes busy/done/abort handshakes to the control side.

Parameters:
holdoff_cycles, 4, idle cycles after each acquisition window before the next delay starts; legal range >=1.
acq_w, 16, width of the acquisition-length field.
sample_frequency, 100000, sample clock rate in Hz; documentation only, no effect on logic.

Ports:
sclock  in  1  sample clock; all logic on rising edge.
rst  in  1  asynchronous reset, active-high.
start  in  1  run request, sampled in IDLE only.
abort  in  1  terminate the run in progress.
count_quarter_period  in  8  delay D in sclock cycles, latched at start.
num_shots  in  8  shots per run N, latched at start.
acq_samples  in  acq_w  acquisition window length A in cycles, latched at start.
busy  out  1  run in progress.
trigger  out  1  one-cycle shot trigger.
acq_active  out  1  acquisition window open.
shot_index  out  8  index of the current shot, 0..N-1.
done  out  1  one-cycle end-of-run pulse.
aborted  out  1  qualifies done; run ended by abort.
cfg_err  out  1  qualifies done; run rejected because N==0 or A==0.

Behaviour:
- Reset: asynchronous, active-high. State goes to IDLE; all outputs, counters and latched configuration clear to 0 immediately. This applies at any point, including mid-shot.
- All outputs are registered and decoded from the state register.
- States: IDLE, DELAY, FIRE, ACQ, HOLD, DONE.
- IDLE:
  - start=1 at edge 0 latches D, N and A.
  - If N==0 or A==0: go to DONE with cfg_err=1; no trigger is issued.
  - Otherwise: go to DELAY with cnt=0 and shot_index=0.
  - busy=1 from edge 1.
- DELAY: cnt increments each cycle. When cnt==D, go to FIRE.
- FIRE: trigger=1 for exactly one cycle, then go to ACQ with cnt=0.
- ACQ: acq_active=1 for exactly A cycles, then go to HOLD.
- HOLD: lasts holdoff_cycles cycles, then:
  - if shot_index==N-1, go to DONE;
  - else shot_index+1, go to DELAY with cnt=0.
- DONE:
  - done=1 for one cycle; aborted and cfg_err are valid in the same cycle.
  - busy stays 1 in this cycle.
  - Next state is IDLE; busy, aborted and cfg_err clear.
- Timing:
  - First trigger is high in the cycle after edge D+2.
  - Shot-to-shot trigger spacing is D+A+holdoff_cycles+2 cycles.
  - D=0 is legal: trigger follows start by 2 edges.
  - D=255 is legal with no wrap: cnt is 8-bit, and the compare is cnt==D.
- Counters:
  - The ACQ/HOLD counter is acq_w bits.
  - A=2^acq_w-1 is legal with no overflow; the terminal compare is cnt==A-1.
- start while busy: ignored, including in the DONE cycle. Config inputs changing while busy have no effect.
- abort=1 in DELAY/FIRE/ACQ/HOLD:
  - next state is DONE with aborted=1;
  - trigger and acq_active drop at that edge;
  - shot_index holds its value for the DONE cycle.
- abort in IDLE or DONE: ignored.
- abort and start together in IDLE: the start is accepted (abort ignored in IDLE).
- shot_index returns to 0 on entry to IDLE.

Test Plan:
- Reset mid-ACQ (D=3, N=2, A=5): assert rst -> busy, trigger, acq_active, shot_index and done all 0 immediately. After release, state is IDLE and no spurious trigger appears.
- D=3, N=1, A=5, holdoff=4; start at edge 0:
  - trigger high after edge 5 only;
  - acq_active high edges 6-10;
  - done pulse after edge 15;
  - busy high edges 1-15.
- D=0, N=3, A=2: three trigger pulses spaced 8 cycles apart; shot_index reads 0, 1, 2 on each pulse; one done with aborted=0.
- start with N=0 or A=0 -> done and cfg_err=1 in the cycle after edge 1; trigger never asserts.
- N=4, abort asserted during shot 1 ACQ:
  - next edge: acq_active=0, done=1, aborted=1, shot_index=1;
  - no further triggers;
  - a start 1 cycle later is ignored, a start 2 cycles later is accepted.
- start re-pulsed and D/N/A changed while busy (D=255 run) -> run completes with the original values; first trigger after edge 257.

Source files
------------

// File: rtl/qpd_shot_sequencer.sv
// qpd_shot_sequencer: runs num_shots measurement shots after a start
// request. Each shot is a programmable delay, a one-cycle trigger, an
// acquisition window of acq_samples cycles and a fixed holdoff. The run
// configuration is captured when the request is accepted, so register
// writes made while busy have no effect on the run in progress.
//
// Control handshake: start is sampled only while the sequencer is idle
// (busy low). An accepted start raises busy one edge later and busy stays
// high up to and including the single-cycle done pulse. aborted and
// cfg_err are meaningful only while done is high. abort is honoured only
// while a shot is in progress. A start or abort seen at any other time is
// dropped, not queued.
module qpd_shot_sequencer #(
  parameter int holdoff_cycles   = 4,
  parameter int acq_w            = 16,
  parameter int sample_frequency = 100000
) (
  input  logic             sclock,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       count_quarter_period,
  input  logic [7:0]       num_shots,
  input  logic [acq_w-1:0] acq_samples,
  output logic             busy,
  output logic             trigger,
  output logic             acq_active,
  output logic [7:0]       shot_index,
  output logic             done,
  output logic             aborted,
  output logic             cfg_err
);

  // Reject parameter sets the counters cannot honour. sample_frequency
  // only documents the sclock rate and has no effect on the logic.
  if (holdoff_cycles < 1 || sample_frequency < 1) begin : g_param_check
    $error("qpd_shot_sequencer: holdoff_cycles and sample_frequency must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELAY = 3'd1,
    FIRE  = 3'd2,
    ACQ   = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Terminal count for the holdoff phase, which reuses the ACQ counter.
  localparam logic [acq_w-1:0] HOLD_LAST = acq_w'(holdoff_cycles - 1);
  localparam logic [acq_w-1:0] ACQ_ONE   = acq_w'(1);

  state_t           state;
  logic             launch;   // start accepted; config captured, run begins next edge
  logic [7:0]       d_q;      // latched delay D
  logic [7:0]       n_q;      // latched shot count N
  logic [acq_w-1:0] a_q;      // latched acquisition length A
  logic [7:0]       cnt_d;    // delay counter, compared directly to D (no wrap at 255)
  logic [acq_w-1:0] cnt_a;    // ACQ/HOLD counter, terminal compare at A-1 (no overflow)

  // Sequencer FSM. Every output is written alongside the state change that
  // defines it, so outputs are registered and always agree with the state.
  always_ff @(posedge sclock or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      launch     <= 1'b0;
      d_q        <= '0;
      n_q        <= '0;
      a_q        <= '0;
      cnt_d      <= '0;
      cnt_a      <= '0;
      busy       <= 1'b0;
      trigger    <= 1'b0;
      acq_active <= 1'b0;
      shot_index <= '0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      // Pulsed outputs default low; the branches below raise them.
      trigger <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            launch <= 1'b0;
            busy   <= 1'b1;
            if (n_q == 8'd0 || a_q == '0) begin
              state   <= DONE;
              done    <= 1'b1;
              cfg_err <= 1'b1;
            end else begin
              state      <= DELAY;
              cnt_d      <= '0;
              shot_index <= '0;
            end
          end else if (start) begin
            launch <= 1'b1;
            d_q    <= count_quarter_period;
            n_q    <= num_shots;
            a_q    <= acq_samples;
          end
        end
        DELAY: begin
          if (abort) begin
            state   <= DONE;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (cnt_d == d_q) begin
            state   <= FIRE;
            trigger <= 1'b1;
          end else begin
            cnt_d <= cnt_d + 8'd1;
          end
        end
        FIRE: begin
          if (abort) begin
            state   <= DONE;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else begin
            state      <= ACQ;
            cnt_a      <= '0;
            acq_active <= 1'b1;
          end
        end
        ACQ: begin
          if (abort) begin
            state      <= DONE;
            acq_active <= 1'b0;
            done       <= 1'b1;
            aborted    <= 1'b1;
          end else if (cnt_a == a_q - ACQ_ONE) begin
            state      <= HOLD;
            cnt_a      <= '0;
            acq_active <= 1'b0;
          end else begin
            cnt_a <= cnt_a + ACQ_ONE;
          end
        end
        HOLD: begin
          if (abort) begin
            state   <= DONE;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (cnt_a == HOLD_LAST) begin
            if (shot_index == n_q - 8'd1) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= DELAY;
              cnt_d      <= '0;
              shot_index <= shot_index + 8'd1;
            end
          end else begin
            cnt_a <= cnt_a + ACQ_ONE;
          end
        end
        DONE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          shot_index <= '0;
        end
        default: begin
          state      <= IDLE;
          launch     <= 1'b0;
          busy       <= 1'b0;
          acq_active <= 1'b0;
          shot_index <= '0;
        end
      endcase
    end
  end

endmodule
